// File: rtl/popcount_pkg.sv
// rtl/popcount_pkg.sv - shared state codes, default timeout and saturating add for the popcount frame sequencer

package popcount_pkg;

  localparam int DEFAULT_TIMEOUT = 255;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_EMIT    = 3'd4;

  // Clamps a + b at 2**w-1; callers keep w below 32.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/popcount_timeout_timer.sv
// rtl/popcount_timeout_timer.sv - per-word wait timer; expires when the count reaches TIMEOUT

module popcount_timeout_timer
  import popcount_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count_q, count_d;

  assign expired = (count_q == W'(TIMEOUT));

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/popcount_frame_ctrl.sv
// rtl/popcount_frame_ctrl.sv - runs the bitcount core once per input word and emits one saturated result per frame

module popcount_frame_ctrl
  import popcount_pkg::*;
#(
  parameter int ACC_W   = 16,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_last,
  output logic             core_start,
  output logic [31:0]      core_in,
  input  logic             core_finish,
  input  logic [31:0]      core_bitcount,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ACC_W-1:0] m_total,
  output logic [CNT_W-1:0] m_words,
  output logic             m_error
);

  logic [2:0]       state_q, state_d;
  logic             s_ready_q, s_ready_d;
  logic             core_start_q, core_start_d;
  logic             m_valid_q, m_valid_d;
  logic             m_error_q, m_error_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [31:0]      core_in_q, core_in_d;
  logic [ACC_W-1:0] acc_q, acc_d, m_total_q, m_total_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, m_words_q, m_words_d;
  logic [31:0]      acc_sum, cnt_sum;
  logic             exit_word;
  logic             timer_load, timer_en, timer_expired;
  logic             unused_bits;

  popcount_timeout_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .enable (timer_en),
    .expired(timer_expired)
  );

  assign unused_bits = ^{core_bitcount[31:6], acc_sum[31:ACC_W], cnt_sum[31:CNT_W]};

  always_comb begin
    state_d     = state_q;
    core_in_d   = core_in_q;
    last_d      = last_q;
    err_d       = err_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    m_total_d   = m_total_q;
    m_words_d   = m_words_q;
    m_error_d   = m_error_q;
    exit_word   = 1'b0;
    timer_load  = 1'b0;
    timer_en    = 1'b0;
    acc_sum     = sat_add(32'(acc_q), {26'd0, core_bitcount[5:0]}, ACC_W);
    cnt_sum     = sat_add(32'(cnt_q), 32'd1, CNT_W);

    case (state_q)
      S_IDLE: begin
        if (s_valid && s_ready_q) begin
          core_in_d = s_data;
          last_d    = s_last;
          state_d   = S_START;
        end
      end
      S_START: begin
        timer_load = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (core_finish) begin
          state_d = S_CAPTURE;
        end else if (timer_expired) begin
          // A timed-out word counts toward the frame but contributes nothing to the total.
          err_d     = 1'b1;
          cnt_d     = cnt_sum[CNT_W-1:0];
          exit_word = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end
      S_CAPTURE: begin
        acc_d     = acc_sum[ACC_W-1:0];
        cnt_d     = cnt_sum[CNT_W-1:0];
        exit_word = 1'b1;
      end
      S_EMIT: begin
        if (m_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (exit_word) begin
      if (last_q) begin
        m_total_d = acc_d;
        m_words_d = cnt_d;
        m_error_d = err_d;
        state_d   = S_EMIT;
      end else begin
        state_d = S_IDLE;
      end
    end

    s_ready_d    = (state_d == S_IDLE);
    core_start_d = (state_d == S_START);
    m_valid_d    = (state_d == S_EMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      s_ready_q    <= 1'b0;
      core_start_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_error_q    <= 1'b0;
      last_q       <= 1'b0;
      err_q        <= 1'b0;
      core_in_q    <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      m_total_q    <= '0;
      m_words_q    <= '0;
    end else begin
      state_q      <= state_d;
      s_ready_q    <= s_ready_d;
      core_start_q <= core_start_d;
      m_valid_q    <= m_valid_d;
      m_error_q    <= m_error_d;
      last_q       <= last_d;
      err_q        <= err_d;
      core_in_q    <= core_in_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      m_total_q    <= m_total_d;
      m_words_q    <= m_words_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign core_start = core_start_q;
  assign core_in    = core_in_q;
  assign m_valid    = m_valid_q;
  assign m_total    = m_total_q;
  assign m_words    = m_words_q;
  assign m_error    = m_error_q;

endmodule

// File: tb/tb_popcount_frame_ctrl.sv
// tb/tb_popcount_frame_ctrl.sv - directed frames against a stub bitcount core

module tb_popcount_frame_ctrl;

  localparam int ACC_W   = 6;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_data;
  logic             s_last;
  logic             core_start;
  logic [31:0]      core_in;
  logic             core_finish;
  logic [31:0]      core_bitcount;
  logic             m_valid;
  logic             m_ready;
  logic [ACC_W-1:0] m_total;
  logic [CNT_W-1:0] m_words;
  logic             m_error;

  int total = 0;
  int bad   = 0;

  popcount_frame_ctrl #(
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .core_start   (core_start),
    .core_in      (core_in),
    .core_finish  (core_finish),
    .core_bitcount(core_bitcount),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_total      (m_total),
    .m_words      (m_words),
    .m_error      (m_error)
  );

  always #5 clk = ~clk;

  // Stub core: finish clears on the start edge, rises 3 cycles later, result lands one cycle after finish.
  logic hang;
  logic start_prev_core;
  logic pend;
  int   cd;

  always @(posedge clk) begin
    start_prev_core <= core_start;
    if (rst) begin
      core_finish   <= 1'b0;
      core_bitcount <= 32'd0;
      pend          <= 1'b0;
      cd            <= 0;
    end else begin
      pend <= 1'b0;
      if (core_start && !start_prev_core) begin
        core_finish <= 1'b0;
        cd          <= hang ? 0 : 3;
      end else if (cd != 0) begin
        cd <= cd - 1;
        if (cd == 1) begin
          core_finish <= 1'b1;
          pend        <= 1'b1;
        end
      end
      if (pend) core_bitcount <= $countones(core_in);
    end
  end

  int   cyc = 0;
  int   start_cnt = 0;
  int   dbl_start = 0;
  int   mv_cnt = 0;
  int   start_cyc = 0;
  int   valid_cyc = 0;
  logic start_prev_mon = 1'b0;
  logic mv_prev = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    start_prev_mon <= core_start;
    mv_prev <= m_valid;
    if (core_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
      if (start_prev_mon) dbl_start <= dbl_start + 1;
    end
    if (m_valid) mv_cnt <= mv_cnt + 1;
    if (m_valid && !mv_prev) valid_cyc <= cyc;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("send_wait", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_data  = $urandom;
    s_last  = 1'($urandom_range(0, 1));
    chk("core_in", core_in, d);
  endtask

  task automatic recv_frame(input string tag, input logic [31:0] et, input logic [31:0] ew,
                            input logic ee, input int hold);
    int   n;
    logic stable;
    n = 0;
    while (!m_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(m_valid), 32'd1);
    chk({tag, "_total"}, 32'(m_total), et);
    chk({tag, "_words"}, 32'(m_words), ew);
    chk({tag, "_error"}, 32'(m_error), 32'(ee));
    if (hold > 0) begin
      stable  = 1'b1;
      s_valid = 1'b1;
      s_data  = 32'h0000_00F0;
      s_last  = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!m_valid || 32'(m_total) !== et || 32'(m_words) !== ew || m_error !== ee || s_ready)
          stable = 1'b0;
      end
      s_valid = 1'b0;
      chk({tag, "_hold"}, 32'(stable), 32'd1);
    end
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_drop"}, 32'(m_valid), 32'd0);
  endtask

  int s0;
  int mv0;

  initial begin
    rst     = 1'b1;
    hang    = 1'b0;
    s_valid = 1'b0;
    s_data  = 32'd0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_out", {m_error, 7'd0, m_words, 10'd0, m_total}, 32'd0);
    chk("rst_core_in", core_in, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", 32'(s_ready), 32'd1);

    // Single full word, result held 10 cycles with m_ready low.
    send_word(32'hFFFF_FFFF, 1'b1);
    recv_frame("ones", 32'd32, 32'd1, 1'b0, 10);

    send_word(32'h0000_0001, 1'b0);
    send_word(32'h0000_0003, 1'b0);
    send_word(32'h8000_0000, 1'b1);
    recv_frame("three", 32'd4, 32'd3, 1'b0, 0);

    s0 = start_cnt;
    send_word(32'h0000_0000, 1'b1);
    recv_frame("zero", 32'd0, 32'd1, 1'b0, 0);
    chk("zero_starts", 32'(start_cnt - s0), 32'd1);

    // 32 + 32 + 32 clamps at 63 in a 6-bit accumulator.
    send_word(32'hFFFF_FFFF, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b1);
    recv_frame("sat", 32'd63, 32'd3, 1'b0, 0);

    // Core never finishes: START cycle plus TIMEOUT+1 WAIT cycles before EMIT.
    hang = 1'b1;
    send_word(32'h0000_00FF, 1'b1);
    recv_frame("tmo", 32'd0, 32'd1, 1'b1, 0);
    chk("tmo_latency", 32'(valid_cyc - start_cyc), 32'(TIMEOUT + 2));
    hang = 1'b0;

    send_word(32'h0000_0F0F, 1'b1);
    recv_frame("after_tmo", 32'd8, 32'd1, 1'b0, 0);

    // Partial frame, then reset while waiting on the core.
    send_word(32'hFFFF_FFFF, 1'b0);
    hang = 1'b1;
    send_word(32'h0000_00FF, 1'b1);
    repeat (5) @(negedge clk);
    mv0 = mv_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
    chk("mid_rst_start", 32'(core_start), 32'd0);
    @(negedge clk);
    chk("mid_rst_idle", 32'(s_ready), 32'd1);
    repeat (40) @(negedge clk);
    chk("mid_rst_no_valid", 32'(mv_cnt - mv0), 32'd0);
    hang = 1'b0;

    send_word(32'h0000_0007, 1'b1);
    recv_frame("post_rst", 32'd3, 32'd1, 1'b0, 0);

    chk("start_back_to_back", 32'(dbl_start), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
